ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
//------------------------------------------------------------------------------
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (inhibit, request,
//               11-bit frame clocked by the device, ack check, timeout).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int c_inh_w = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int c_to_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_idle      = 3'd0;
    localparam logic [2:0] c_inhibit   = 3'd1;
    localparam logic [2:0] c_req       = 3'd2;
    localparam logic [2:0] c_send      = 3'd3;
    localparam logic [2:0] c_ack       = 3'd4;
    localparam logic [2:0] c_wait_idle = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [2:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic [7:0]         r_byte;
    logic               r_parity;
    logic [c_inh_w-1:0] r_inh_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [3:0]         r_edge_cnt;
    logic               r_data_drive;
    logic               r_done;
    logic               r_err;

    logic w_clk_s;
    logic w_data_s;
    logic w_fall;
    logic w_active;
    logic w_timeout;
    logic w_inh_done;
    logic w_stop_edge;
    logic w_bus_idle;
    logic w_accept;
    logic w_done_set;
    logic w_err_set;

    // Stage [2] of the clock chain is only the previous synchronized value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
        end
    end

    assign w_clk_s     = r_clk_sync[1];
    assign w_data_s    = r_data_sync[1];
    assign w_fall      = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_active    = (r_state == c_send) || (r_state == c_ack) || (r_state == c_wait_idle);
    assign w_timeout   = w_active && (r_to_cnt == c_to_last);
    assign w_inh_done  = (r_inh_cnt == c_inh_last);
    assign w_stop_edge = w_fall && (r_edge_cnt == 4'd9);
    assign w_bus_idle  = w_clk_s && w_data_s;
    assign w_accept    = (r_state == c_idle) && tx_valid;
    assign w_done_set  = (r_state == c_wait_idle) && !w_timeout && w_bus_idle;
    assign w_err_set   = w_timeout || ((r_state == c_ack) && w_fall && w_data_s);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timeout has priority over any bus progress in the device-clocked states.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle: begin
                if (tx_valid) begin
                    w_state_next = c_inhibit;
                end
            end
            c_inhibit: begin
                if (w_inh_done) begin
                    w_state_next = c_req;
                end
            end
            c_req: begin
                w_state_next = c_send;
            end
            c_send: begin
                if (w_timeout) begin
                    w_state_next = c_idle;
                end else if (w_stop_edge) begin
                    w_state_next = c_ack;
                end
            end
            c_ack: begin
                if (w_timeout) begin
                    w_state_next = c_idle;
                end else if (w_fall) begin
                    w_state_next = w_data_s ? c_idle : c_wait_idle;
                end
            end
            c_wait_idle: begin
                if (w_timeout || w_bus_idle) begin
                    w_state_next = c_idle;
                end
            end
            default: begin
                w_state_next = c_idle;
            end
        endcase
    end

    always_comb begin
        tx_ready    = (r_state == c_idle);
        busy        = (r_state != c_idle);
        ps2_clk_oe  = (r_state == c_inhibit) || (r_state == c_req);
        ps2_data_oe = (r_state == c_req) || ((r_state == c_send) && r_data_drive);
        done        = r_done;
        err         = r_err;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_byte       <= 8'h00;
            r_parity     <= 1'b0;
            r_inh_cnt    <= '0;
            r_to_cnt     <= '0;
            r_edge_cnt   <= 4'd0;
            r_data_drive <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_byte   <= tx_data;
                r_parity <= ~^tx_data;
            end

            if (r_state == c_inhibit) begin
                r_inh_cnt <= r_inh_cnt + 1'b1;
            end else begin
                r_inh_cnt <= '0;
            end

            if (w_active) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end

            // Start bit stays driven from the request cycle until edge 1.
            if (r_state == c_req) begin
                r_edge_cnt   <= 4'd0;
                r_data_drive <= 1'b1;
            end else if ((r_state == c_send) && w_fall) begin
                r_edge_cnt <= r_edge_cnt + 4'd1;
                if (r_edge_cnt < 4'd8) begin
                    r_data_drive <= ~r_byte[r_edge_cnt[2:0]];
                end else if (r_edge_cnt == 4'd8) begin
                    r_data_drive <= ~r_parity;
                end else begin
                    r_data_drive <= 1'b0;
                end
            end else if (r_state != c_send) begin
                r_data_drive <= 1'b0;
            end

            r_done <= w_done_set;
            r_err  <= w_err_set;
        end
    end

endmodule

`default_nettype wire
